// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    CAPTURE,
    VALID
  } state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction ROM port: fetch stage drives enable/address, ROM returns data one cycle later.
interface inst_fetch_if #(
  parameter int unsigned ADDR_W = 10
);

  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_data;

  modport master (
    output rom_en,
    output rom_addr,
    input  rom_data
  );

  modport slave (
    input  rom_en,
    input  rom_addr,
    output rom_data
  );

endinterface

// File: rtl/next_pc_calc.sv
// Next-PC selection: jump has priority over a taken branch, which beats sequential.
module next_pc_calc
  import fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  output logic [31:0] next_pc
);

  logic [31:0] pc4;

  assign pc4 = pc + PC_STEP;

  always_comb begin
    next_pc = pc4;
    if (jump) begin
      next_pc = {pc4[31:28], jump_index, 2'b00};
    end else if (branch_taken) begin
      // Word offset scaled to bytes; the top two offset bits fall off the 32-bit result.
      next_pc = pc4 + {branch_offset[29:0], 2'b00};
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: PC register, synchronous-ROM read sequencing and instruction capture,
// advanced one instruction per divider tick.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                step,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [31:0]         branch_offset,
  input  logic                jump,
  input  logic [25:0]         jump_index,
  inst_fetch_if.master        rom,
  output logic [31:0]         pc,
  output logic [31:0]         inst,
  output logic                inst_valid,
  output logic [15:0]         retire_count
);

  state_t      state;
  state_t      state_next;
  logic        advance;
  logic        load_inst;
  logic        retire;
  logic [31:0] next_pc;

  assign advance      = step & ~stall;
  assign rom.rom_addr = pc[ADDR_W+1:2];

  next_pc_calc u_next_pc (
    .pc            (pc),
    .jump          (jump),
    .jump_index    (jump_index),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .next_pc       (next_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Steps arriving in FETCH/CAPTURE fall through unhandled, so they are dropped.
  always_comb begin
    state_next = state;
    rom.rom_en = 1'b0;
    load_inst  = 1'b0;
    retire     = 1'b0;
    case (state)
      IDLE: begin
        if (advance) state_next = FETCH;
      end
      FETCH: begin
        rom.rom_en = 1'b1;
        state_next = CAPTURE;
      end
      CAPTURE: begin
        load_inst  = 1'b1;
        state_next = VALID;
      end
      VALID: begin
        if (advance) begin
          retire     = 1'b1;
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= RESET_PC;
      inst         <= '0;
      inst_valid   <= 1'b0;
      retire_count <= '0;
    end else begin
      if (load_inst) begin
        inst       <= rom.rom_data;
        inst_valid <= 1'b1;
      end
      if (retire) begin
        pc           <= next_pc;
        inst_valid   <= 1'b0;
        retire_count <= retire_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Randomised scoreboard bench for inst_fetch with a behavioural PC/ROM reference model.
module tb_inst_fetch;

  localparam int unsigned ADDR_W = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        step;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        inst_valid;
  logic [15:0] retire_count;

  inst_fetch_if #(.ADDR_W(ADDR_W)) rom_bus ();

  inst_fetch #(
    .RESET_PC (32'h0000_0000),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .step          (step),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .rom           (rom_bus),
    .pc            (pc),
    .inst          (inst),
    .inst_valid    (inst_valid),
    .retire_count  (retire_count)
  );

  always #5 clk = ~clk;

  logic [31:0] rom_mem [1024];

  always @(posedge clk) begin
    if (rom_bus.rom_en) rom_bus.rom_data <= rom_mem[rom_bus.rom_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [15:0] count;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [31:0] model_pc;
  logic [15:0] model_count;
  bit          model_idle;
  logic        prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic j,
                                           input logic [25:0] idx, input logic b,
                                           input logic [31:0] off);
    logic [31:0] seq;
    seq = cur + 32'd4;
    if (j) return {seq[31:28], idx, 2'b00};
    if (b) return seq + off * 32'd4;
    return seq;
  endfunction

  // Monitor: every new valid instruction must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (inst_valid && !prev_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", {16'h0, retire_count}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("pc", pc, e.pc);
        chk("inst", inst, e.inst);
        chk("retire_count", {16'h0, retire_count}, {16'h0, e.count});
        chk("latency", 32'(cyc), 32'(e.due));
      end
    end
    prev_valid = inst_valid;
  end

  task automatic wait_valid();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (inst_valid) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) chk("wait_valid_timeout", {31'h0, inst_valid}, 32'h1);
  endtask

  task automatic do_step(input logic j, input logic [25:0] idx, input logic b,
                         input logic [31:0] off);
    exp_t e;
    if (!model_idle) wait_valid();
    @(negedge clk);
    step          = 1'b1;
    stall         = 1'b0;
    jump          = j;
    jump_index    = idx;
    branch_taken  = b;
    branch_offset = off;
    if (!model_idle) begin
      model_pc    = ref_next(model_pc, j, idx, b, off);
      model_count = model_count + 16'd1;
    end
    model_idle = 1'b0;
    e.pc    = model_pc;
    e.inst  = rom_mem[model_pc[11:2]];
    e.count = model_count;
    e.due   = cyc + 3;
    sb.push_back(e);
    @(negedge clk);
    step         = 1'b0;
    jump         = 1'b0;
    branch_taken = 1'b0;
    chk("rom_en_fetch", {31'h0, rom_bus.rom_en}, 32'h1);
    chk("rom_addr_fetch", {22'h0, rom_bus.rom_addr}, {22'h0, model_pc[11:2]});
    chk("pc_at_fetch", pc, model_pc);
  endtask

  task automatic reset_model();
    sb.delete();
    model_pc    = 32'h0;
    model_count = 16'h0;
    model_idle  = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [31:0] off;
    rst           = 1'b1;
    step          = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_offset = '0;
    jump          = 1'b0;
    jump_index    = '0;
    for (int i = 0; i < 1024; i++) rom_mem[i] = $urandom;
    rom_mem[0] = 32'h2008_0005;
    reset_model();

    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_count", {16'h0, retire_count}, 32'h0);
    chk("rst_rom_en", {31'h0, rom_bus.rom_en}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_valid", {31'h0, inst_valid}, 32'h0);

    do_step(1'b0, '0, 1'b0, '0);
    repeat (3) do_step(1'b0, '0, 1'b0, '0);
    do_step(1'b0, '0, 1'b1, 32'hFFFF_FFFE);
    do_step(1'b0, '0, 1'b1, 32'hFFFF_FFFE);
    do_step(1'b1, 26'h4, 1'b0, '0);
    do_step(1'b1, 26'h40, 1'b1, 32'd5);

    // Stall in VALID: five step pulses must all be swallowed.
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      stall = 1'b1;
      step  = 1'b1;
      @(negedge clk);
      step = 1'b0;
      @(negedge clk);
    end
    stall = 1'b0;
    chk("stall_pc", pc, model_pc);
    chk("stall_inst", inst, rom_mem[model_pc[11:2]]);
    chk("stall_count", {16'h0, retire_count}, {16'h0, model_count});
    chk("stall_valid", {31'h0, inst_valid}, 32'h1);

    // Steps during FETCH and CAPTURE carry a jump that must not be applied.
    do_step(1'b0, '0, 1'b0, '0);
    step       = 1'b1;
    jump       = 1'b1;
    jump_index = 26'h3FF_FFFF;
    @(negedge clk);
    @(negedge clk);
    step = 1'b0;
    jump = 1'b0;
    repeat (3) @(negedge clk);
    chk("ignore_pc", pc, model_pc);
    chk("ignore_count", {16'h0, retire_count}, {16'h0, model_count});

    off = (32'hFFFF_FFF8 - model_pc) >> 2;
    do_step(1'b0, '0, 1'b1, off);
    do_step(1'b0, '0, 1'b0, '0);

    for (int n = 0; n < 40; n++) begin
      logic        j;
      logic        b;
      logic [25:0] idx;
      logic [31:0] o;
      if ($urandom_range(0, 3) == 0) begin
        wait_valid();
        @(negedge clk);
        stall = 1'b1;
        step  = 1'b1;
        @(negedge clk);
        step  = 1'b0;
        stall = 1'b0;
      end
      j   = ($urandom_range(0, 9) < 2);
      b   = ($urandom_range(0, 2) == 0);
      idx = 26'($urandom);
      o   = 32'($urandom_range(0, 128)) - 32'd64;
      do_step(j, idx, b, o);
    end

    // Async reset in the middle of CAPTURE.
    do_step(1'b0, '0, 1'b0, '0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_inst", inst, 32'h0);
    chk("midrst_valid", {31'h0, inst_valid}, 32'h0);
    chk("midrst_count", {16'h0, retire_count}, 32'h0);
    chk("midrst_rom_en", {31'h0, rom_bus.rom_en}, 32'h0);
    reset_model();
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("postrst_idle_valid", {31'h0, inst_valid}, 32'h0);
    chk("postrst_rom_en", {31'h0, rom_bus.rom_en}, 32'h0);
    do_step(1'b0, '0, 1'b0, '0);
    do_step(1'b0, '0, 1'b0, '0);

    wait_valid();
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage for the single-cycle MIPS teaching core. Holds the PC, issues reads to the synchronous-read instruction ROM (one-cycle registered output), captures the returned word and presents it with a valid flag to the main/ALU decoder. On each `step` it computes the next PC from sequential, branch and jump sources. `step` comes from the clock-divider tick, so every instruction stays visible on the board LEDs for a full divided period.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC after reset; bits [1:0] must be 0
- `ADDR_W`, 10, ROM word-address width

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `step`  in  1  advance request, single-cycle pulse (divider tick)
- `stall`  in  1  hold current instruction; overrides `step`
- `branch_taken`  in  1  branch resolved taken (branch & zero), sampled with `step`
- `branch_offset`  in  32  sign-extended immediate, in words
- `jump`  in  1  jump decoded, sampled with `step`
- `jump_index`  in  26  inst[25:0] of jump instruction
- `rom_en`  out  1  ROM read enable
- `rom_addr`  out  ADDR_W  ROM word address = `pc[ADDR_W+1:2]`
- `rom_data`  in  32  ROM read data, valid one cycle after the enabled address edge
- `pc`  out  32  address of the instruction on `inst`
- `inst`  out  32  captured instruction word
- `inst_valid`  out  1  `inst` is valid for `pc`
- `retire_count`  out  16  instructions consumed, wraps 16'hFFFF -> 0

## Operation
- States: IDLE, FETCH, CAPTURE, VALID.
- Reset (async, immediate, no clock required): state=IDLE, `pc`=RESET_PC, `inst`=0, `inst_valid`=0, `retire_count`=0. `rom_en`=0; `rom_addr` follows `pc`. Any in-flight ROM data is discarded.
- IDLE: `step` & !`stall` -> FETCH, `pc` unchanged. Otherwise stay.
- FETCH: `rom_en`=1, `rom_addr`=`pc[ADDR_W+1:2]`. Always -> CAPTURE after one cycle.
- CAPTURE: `rom_en`=0. `inst`<=`rom_data`, `inst_valid`<=1 -> VALID.
- VALID: `inst_valid`=1. `step` & !`stall` -> `pc`<=next_pc, `inst_valid`<=0, `retire_count`+=1, -> FETCH. `stall`=1 holds `pc`, `inst` and `inst_valid`.
- `step` in FETCH or CAPTURE is ignored, not queued.
- next_pc, priority jump > branch > sequential; pc4 = `pc`+4:
  - jump: {pc4[31:28], `jump_index`, 2'b00}
  - branch_taken: pc4 + (`branch_offset` << 2)
  - else: pc4
- All PC arithmetic is 32-bit modulo 2^32; carries are dropped. `pc`[1:0] stays 00 by construction. PC bits above ADDR_W+1 are not decoded, so the ROM aliases.

## Timing
- Step in VALID at cycle t: FETCH at t+1, CAPTURE at t+2, `inst_valid`=1 with new `inst` from t+3.
- First instruction after reset: step at t in IDLE gives `inst_valid` at t+3.
- `pc` updates at the t edge and is stable while `inst_valid`=0. The decoder uses `inst` only when `inst_valid`=1.
- `rom_en` and `rom_addr` are combinational from state and `pc`. `inst`, `inst_valid`, `pc` and `retire_count` are registered.
- Reset asserted mid-FETCH or mid-CAPTURE: outputs take reset values in the same cycle. After deassertion the block waits in IDLE for the next `step`.

## Structure
- Package `fetch_pkg`: state enum (IDLE, FETCH, CAPTURE, VALID) and constant `PC_STEP`=32'd4.
- Sub-module `next_pc_calc`: combinational. Inputs are pc, jump, jump_index, branch_taken and branch_offset; output is next_pc. It is reused by the branch-unit bench.
- Top `inst_fetch` contains the FSM, the PC, instruction and counter registers, and the ROM port.

## Test plan
- Reset, then one step with ROM[0]=32'h2008_0005: `rom_en`=1 with `rom_addr`=0 at t+1. `inst`=32'h2008_0005, `inst_valid`=1, `pc`=0 from t+3.
- Three steps with no branch or jump: `pc` goes 0 -> 4 -> 8 -> C, `rom_addr` goes 0,1,2,3, `retire_count`=3.
- `pc`=32'h8, step with `branch_taken`=1 and `branch_offset`=32'hFFFF_FFFE: `pc`=32'h4.
- `pc`=32'h10, step with `jump`=1, `branch_taken`=1 and `jump_index`=26'h40: `pc`=32'h100, so jump wins.
- Hold and ignore:
  - `stall`=1 while in VALID with five step pulses: `pc`, `inst` and `retire_count` unchanged, `inst_valid` stays 1.
  - Step pulse during FETCH: ignored.
- Reset and wrap-around:
  - `rst` pulse mid-CAPTURE: outputs reset immediately, no clock edge needed.
  - `pc`=32'hFFFF_FFFC, sequential step: `pc`=32'h0.
